rule30_uart_tx: RTL and testbench

- Byte-stream UART transmitter that sits downstream of the Rule 30 driver.
- Accepts ASCII bytes for each rendered row over a valid/ready handshake and buffers them in a small FIFO.
- Serialises them 8N1, LSB first, onto the chip's TX pin (uo_out[4]).
- Decouples character generation from line rate, so the upstream stage can burst a row and stall only when the FIFO fills.

---
 rtl/rule30_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_rule30_uart_tx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule30_uart_tx.sv
// Rule 30 UART transmitter: small byte FIFO feeding an 8N1 serialiser, LSB first.
// Optional even parity (8E1) is compiled in when RULE30_UART_PARITY_EN is defined.
module rule30_uart_tx #(
  parameter int unsigned CLK_DIV    = 87,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                tx_enable,
  output logic                SOUT,
  output logic                busy,
  output logic [DEPTH_LOG2:0] fifo_count
);

  localparam int unsigned         Depth     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [15:0]         DivLoad   = 16'(CLK_DIV - 1);

`ifdef RULE30_UART_PARITY_EN
  localparam int unsigned BitW = 4;
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  localparam int unsigned BitW = 3;
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  localparam logic [BitW-1:0] LastBit = BitW'(7);

  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push, pop;
  logic [7:0]            head;

  state_e                state_q, state_d;
  logic [15:0]           div_q, div_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  sout_q, sout_d;
  logic                  busy_q;
  logic                  bit_done, can_start;
`ifdef RULE30_UART_PARITY_EN
  logic                  parity_q;
`endif

  // Ready depends only on the registered count, so there is no path from in_valid.
  assign in_ready   = (count_q != FullCount);
  assign push       = in_valid & in_ready;
  assign head       = mem[rd_ptr_q];
  assign fifo_count = count_q;
  assign SOUT       = sout_q;
  assign busy       = busy_q;
  assign bit_done   = (div_q == 16'd0);
  assign can_start  = (count_q != '0) && tx_enable;

  // FIFO storage; no reset needed since count gates every read.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the depth.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serialiser state, bit divider, bit counter and shift register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef RULE30_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef RULE30_UART_PARITY_EN
      if (pop) parity_q <= ^head;
`endif
    end
  end

  // Next-state logic; a pop loads the head byte and starts a new frame.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (can_start) begin
          pop     = 1'b1;
          shift_d = head;
          div_d   = DivLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          div_d   = DivLoad;
          bit_d   = '0;
          state_d = StData;
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          div_d   = DivLoad;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
`ifdef RULE30_UART_PARITY_EN
          if (bit_q == LastBit) state_d = StParity;
`else
          if (bit_q == LastBit) state_d = StStop;
`endif
        end else begin
          div_d = div_q - 16'd1;
        end
      end
`ifdef RULE30_UART_PARITY_EN
      StParity: begin
        if (bit_done) begin
          div_d   = DivLoad;
          state_d = StStop;
        end else begin
          div_d = div_q - 16'd1;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          // Chain straight into the next start bit so the stop bit is never stretched.
          if (can_start) begin
            pop     = 1'b1;
            shift_d = head;
            div_d   = DivLoad;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the current state, registered one cycle later onto SOUT.
  always_comb begin
    sout_d = 1'b1;
    case (state_q)
      StStart:  sout_d = 1'b0;
      StData:   sout_d = shift_q[0];
`ifdef RULE30_UART_PARITY_EN
      StParity: sout_d = parity_q;
`endif
      default:  sout_d = 1'b1;
    endcase
  end

  // Registered line and busy flag, aligned so busy covers exactly the frame on SOUT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sout_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      sout_q <= sout_d;
      busy_q <= (state_q != StIdle);
    end
  end

endmodule

// File: tb/tb_rule30_uart_tx.sv
// Directed bench for rule30_uart_tx at CLK_DIV=4, depth 4.
`timescale 1ns/1ps
module tb_rule30_uart_tx;

  localparam int Div = 4;
`ifdef RULE30_UART_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       tx_enable = 1'b0;
  logic       in_ready, SOUT, busy;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  logic                 ok_p, ok_c, found_c, par6;
  logic [7:0]           d6;
  logic [FrameBits-1:0] pat1;
  logic [7:0]           t2_exp [5];
  logic [7:0]           t3_exp [13];

  always #5 CLK = ~CLK;

  rule30_uart_tx #(
    .CLK_DIV   (Div),
    .DEPTH_LOG2(2)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_enable (tx_enable),
    .SOUT      (SOUT),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid low.
  task automatic push_byte(input logic [7:0] b, output logic ok);
    ok       = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (in_ready) begin
        @(posedge CLK);
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output logic found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (SOUT === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Starts at the negedge of the first start-bit cycle, ends at the last stop-bit cycle.
  task automatic read_frame(output logic [7:0] data, output logic par, output logic ok);
    logic s;
    data = 8'h00;
    par  = 1'b0;
    ok   = 1'b1;
    for (int b = 0; b < FrameBits; b++) begin
      for (int c = 0; c < Div; c++) begin
        if (b != 0 || c != 0) @(negedge CLK);
        s = SOUT;
        if (busy !== 1'b1) ok = 1'b0;
        if (b == 0) begin
          if (s !== 1'b0) ok = 1'b0;
        end else if (b <= 8) begin
          if (c == 0) data[b-1] = s;
          else if (s !== data[b-1]) ok = 1'b0;
        end else if (b == 9 && FrameBits == 11) begin
          if (c == 0) par = s;
          else if (s !== par) ok = 1'b0;
        end else begin
          if (s !== 1'b1) ok = 1'b0;
        end
      end
    end
  endtask

  task automatic recv_check(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    logic       p, ok;
    read_frame(d, p, ok);
    chk({tag, "_data"}, 32'(d), 32'(exp));
    chk({tag, "_frame"}, 32'(ok), 32'd1);
`ifdef RULE30_UART_PARITY_EN
    chk({tag, "_par"}, 32'(p), 32'(^exp));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RULE30_UART_PARITY_EN
    pat1 = 11'b10010101010;
`else
    pat1 = 10'b1010101010;
`endif
    t2_exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    t3_exp = '{8'h11, 8'h22, 8'h33, 8'h01, 8'h80, 8'hFF, 8'h00, 8'hC3,
               8'h5A, 8'h96, 8'h69, 8'hE7, 8'h18};

    // Reset state, checked before any clock edge.
    #1 RST_N = 1'b0;
    #2;
    chk("rst_sout", 32'(SOUT), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    tx_enable = 1'b1;

    // 1: single 0x55, exact cycle timing.
    push_byte(8'h55, ok_p);
    chk("t1_push", 32'(ok_p), 32'd1);
    chk("t1_sout_n0", 32'(SOUT), 32'd1);
    @(negedge CLK);
    chk("t1_sout_n1", 32'(SOUT), 32'd1);
    chk("t1_count_popped", 32'(fifo_count), 32'd0);
    @(negedge CLK);
    for (int j = 0; j < FrameBits * Div; j++) begin
      chk("t1_sout", 32'(SOUT), 32'(pat1[j/Div]));
      chk("t1_busy", 32'(busy), 32'd1);
      @(negedge CLK);
    end
    chk("t1_end_busy", 32'(busy), 32'd0);
    chk("t1_end_sout", 32'(SOUT), 32'd1);
    chk("t1_end_count", 32'(fifo_count), 32'd0);

    // 2: fill while disabled, then back-to-back drain.
    tx_enable = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = t2_exp[i];
      chk("t2_ready_before", 32'(in_ready), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
    end
    in_data = 8'h45;
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    chk("t2_full_count", 32'(fifo_count), 32'd4);
    repeat (6) begin
      @(negedge CLK);
      chk("t2_hold_sout", 32'(SOUT), 32'd1);
      chk("t2_hold_ready", 32'(in_ready), 32'd0);
    end
    tx_enable = 1'b1;
    fork
      begin
        push_byte(8'h45, ok_p);
        chk("t2_push45", 32'(ok_p), 32'd1);
      end
      begin
        wait_start(20, found_c);
        chk("t2_start", 32'(found_c), 32'd1);
        for (int k = 0; k < 5; k++) begin
          recv_check("t2", t2_exp[k]);
          if (k < 4) begin
            @(negedge CLK);
            chk("t2_b2b", 32'(SOUT), 32'd0);
          end
        end
      end
    join

    // 3: push and pop on the same edge at count 2, then order across pointer wrap.
    @(negedge CLK);
    tx_enable = 1'b0;
    push_byte(8'h11, ok_p);
    push_byte(8'h22, ok_p);
    chk("t3_count2", 32'(fifo_count), 32'd2);
    in_data   = 8'h33;
    in_valid  = 1'b1;
    tx_enable = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    chk("t3_count_same", 32'(fifo_count), 32'd2);
    fork
      begin
        for (int i = 3; i < 13; i++) begin
          push_byte(t3_exp[i], ok_p);
          chk("t3_push", 32'(ok_p), 32'd1);
        end
      end
      begin
        for (int k = 0; k < 13; k++) begin
          wait_start(200, found_c);
          chk("t3_start", 32'(found_c), 32'd1);
          recv_check("t3", t3_exp[k]);
        end
      end
    join

    // 4: asynchronous reset during data bit 3 of 0xA5.
    @(negedge CLK);
    push_byte(8'hA5, ok_p);
    push_byte(8'h99, ok_p);
    wait_start(20, found_c);
    chk("t4_start", 32'(found_c), 32'd1);
    repeat (17) @(negedge CLK);
    chk("t4_bit3", 32'(SOUT), 32'd0);
    chk("t4_count_pre", 32'(fifo_count), 32'd1);
    #1 RST_N = 1'b0;
    #1;
    chk("t4_rst_sout", 32'(SOUT), 32'd1);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_count", 32'(fifo_count), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    push_byte(8'h0F, ok_p);
    wait_start(20, found_c);
    chk("t4_start_0f", 32'(found_c), 32'd1);
    recv_check("t4", 8'h0F);

    // 5: tx_enable dropped mid-frame; the frame completes and the queue holds.
    @(negedge CLK);
    push_byte(8'h3C, ok_p);
    push_byte(8'h7E, ok_p);
    wait_start(20, found_c);
    chk("t5_start", 32'(found_c), 32'd1);
    fork
      recv_check("t5_3c", 8'h3C);
      begin
        repeat (8) @(negedge CLK);
        tx_enable = 1'b0;
      end
    join
    repeat (6) @(negedge CLK);
    chk("t5_idle_sout", 32'(SOUT), 32'd1);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_count", 32'(fifo_count), 32'd1);
    tx_enable = 1'b1;
    wait_start(20, found_c);
    chk("t5_start_7e", 32'(found_c), 32'd1);
    recv_check("t5_7e", 8'h7E);
    @(negedge CLK);
    chk("t5_end_count", 32'(fifo_count), 32'd0);
    chk("t5_end_busy", 32'(busy), 32'd0);

`ifdef RULE30_UART_PARITY_EN
    // 6: 8E1 frames, 44 cycles each, parity of 0x07 is 1 and of 0x03 is 0.
    @(negedge CLK);
    push_byte(8'h07, ok_p);
    push_byte(8'h03, ok_p);
    wait_start(20, found_c);
    chk("t6_start", 32'(found_c), 32'd1);
    read_frame(d6, par6, ok_c);
    chk("t6_07_data", 32'(d6), 32'h07);
    chk("t6_07_par", 32'(par6), 32'd1);
    chk("t6_07_frame", 32'(ok_c), 32'd1);
    @(negedge CLK);
    chk("t6_b2b", 32'(SOUT), 32'd0);
    read_frame(d6, par6, ok_c);
    chk("t6_03_data", 32'(d6), 32'h03);
    chk("t6_03_par", 32'(par6), 32'd0);
    chk("t6_03_frame", 32'(ok_c), 32'd1);
    @(negedge CLK);
    chk("t6_end_sout", 32'(SOUT), 32'd1);
    chk("t6_end_busy", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
